atom_state_reader: RTL and testbench

- Control-plane observer for a single-register stateful atom.
- Samples each packet's state transition (old state = atom o__read, new state = atom o__write) into a small log FIFO.
- Lets a control-plane agent drain the log over a request/acknowledge handshake.
- Sits beside the atom in the packet-transaction pipeline. It is the reading end of the atom's state-write path and never alters atom state.

---
 rtl/atom_state_reader.sv | 116 +++++++++++
 tb/tb_atom_state_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atom_state_reader.sv
// Control-plane observer for a stateful atom: logs (old, new) state pairs into a
// small FIFO and returns them to a control-plane agent over a req/ack handshake.
module atom_state_reader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pkt_valid,
    input  logic [WIDTH-1:0]         i__read,
    input  logic [WIDTH-1:0]         i__write,
    input  logic                     only_changes,
    input  logic                     clear,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic                     rd_empty,
    output logic [WIDTH-1:0]         rd_old,
    output logic [WIDTH-1:0]         rd_new,
    output logic                     rd_changed,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                 state;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]       head_old;
    logic [WIDTH-1:0]       head_new;
    logic                   cap;
    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count  = wr_ptr - rd_ptr;
    assign cap    = pkt_valid && (!only_changes || (i__read != i__write));
    assign accept = (state == IDLE) && rd_req && !clear;
    assign pop    = accept && (count != '0);
    assign push   = cap && !clear && ((count != FULL_CNT) || pop);
    assign drop   = cap && !clear && (count == FULL_CNT) && !pop;

    assign {head_old, head_new} = mem[rd_ptr[AW-1:0]];

    // NOTE: the log storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {i__read, i__write};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Read FSM; the response registers hold their value until the next acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ack     <= 1'b0;
            rd_empty   <= 1'b0;
            rd_old     <= '0;
            rd_new     <= '0;
            rd_changed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd_ack <= 1'b0;
                    if (accept) begin
                        state  <= RESP;
                        rd_ack <= 1'b1;
                        if (pop) begin
                            rd_empty   <= 1'b0;
                            rd_old     <= head_old;
                            rd_new     <= head_new;
                            rd_changed <= (head_old != head_new);
                        end else begin
                            rd_empty   <= 1'b1;
                            rd_old     <= '0;
                            rd_new     <= '0;
                            rd_changed <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    rd_ack <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    rd_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atom_state_reader.sv
// Self-checking bench for atom_state_reader: vector table for the basic flows,
// hand sequences for overflow, full-with-pop, clear and mid-burst reset.
module tb_atom_state_reader;

    localparam int W        = 32;
    localparam int DEPTH    = 8;
    localparam int DROP_W   = 16;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   pkt_valid;
    logic [W-1:0]           i__read;
    logic [W-1:0]           i__write;
    logic                   only_changes;
    logic                   clear;
    logic                   rd_req;
    logic                   rd_ack;
    logic                   rd_empty;
    logic [W-1:0]           rd_old;
    logic [W-1:0]           rd_new;
    logic                   rd_changed;
    logic [$clog2(DEPTH):0] count;
    logic [DROP_W-1:0]      drop_cnt;

    atom_state_reader #(.WIDTH(W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_valid    (pkt_valid),
        .i__read      (i__read),
        .i__write     (i__write),
        .only_changes (only_changes),
        .clear        (clear),
        .rd_req       (rd_req),
        .rd_ack       (rd_ack),
        .rd_empty     (rd_empty),
        .rd_old       (rd_old),
        .rd_new       (rd_new),
        .rd_changed   (rd_changed),
        .count        (count),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         empty;
        logic [W-1:0] o_s;
        logic [W-1:0] n_s;
        logic         changed;
    } resp_t;

    typedef struct {
        logic         pv;
        logic [W-1:0] r;
        logic [W-1:0] w;
        logic         oc;
        logic         req;
        logic         e_ack;
        logic         e_empty;
        logic [W-1:0] e_old;
        logic [W-1:0] e_new;
        logic         e_chg;
        int           e_cnt;
    } vec_t;

    int             n_tests = 0;
    int             n_fail  = 0;
    resp_t          exp_q[$];
    logic [2*W-1:0] m_log[$];
    int             m_drop = 0;
    logic           m_resp = 1'b0;
    vec_t           vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_log.delete();
        exp_q.delete();
        m_drop = 0;
        m_resp = 1'b0;
    endtask

    // Drives one cycle, advances the reference model, then checks after the edge.
    task automatic step(input logic pv, input logic [W-1:0] r, input logic [W-1:0] w,
                        input logic oc, input logic clr, input logic req);
        logic  cap;
        logic  acc;
        resp_t e;
        pkt_valid    = pv;
        i__read      = r;
        i__write     = w;
        only_changes = oc;
        clear        = clr;
        rd_req       = req;
        cap = pv && (!oc || (r != w));
        acc = !m_resp && req && !clr;
        if (clr) begin
            m_log.delete();
            m_drop = 0;
        end else begin
            if (acc) begin
                if (m_log.size() > 0) begin
                    e.empty = 1'b0;
                    {e.o_s, e.n_s} = m_log.pop_front();
                    e.changed = (e.o_s != e.n_s);
                end else begin
                    e.empty   = 1'b1;
                    e.o_s     = '0;
                    e.n_s     = '0;
                    e.changed = 1'b0;
                end
                exp_q.push_back(e);
            end
            if (cap) begin
                if (m_log.size() < DEPTH) m_log.push_back({r, w});
                else if (m_drop < DROP_MAX) m_drop++;
            end
        end
        m_resp = acc;
        @(posedge clk);
        #1;
        check("rd_ack", rd_ack, acc);
        check("count", count, m_log.size());
        check("drop_cnt", drop_cnt, m_drop);
        if (rd_ack) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_ack: got ack, expected no response (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_empty", rd_empty, e.empty);
                check("sb_old", rd_old, e.o_s);
                check("sb_new", rd_new, e.n_s);
                check("sb_changed", rd_changed, e.changed);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, rd_ack, 0);
        check({tag, "_empty"}, rd_empty, 0);
        check({tag, "_old"}, rd_old, 0);
        check({tag, "_new"}, rd_new, 0);
        check({tag, "_changed"}, rd_changed, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_drop"}, drop_cnt, 0);
    endtask

    function automatic vec_t mk(input logic pv, input int r, input int w, input logic oc,
                                input logic req, input logic ack, input logic emp,
                                input int o, input int n, input logic chg, input int cnt);
        vec_t v;
        v.pv = pv; v.r = W'(r); v.w = W'(w); v.oc = oc; v.req = req;
        v.e_ack = ack; v.e_empty = emp; v.e_old = W'(o); v.e_new = W'(n);
        v.e_chg = chg; v.e_cnt = cnt;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] last_new;

        pkt_valid = 0; i__read = '0; i__write = '0; only_changes = 0;
        clear = 0; rd_req = 0; rst_n = 0;
        #12;
        check_all_zero("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        // Empty read after reset, then the three-capture flows with and without only_changes.
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 6, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 6, 6, 0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1, 6, 9, 0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 5, 6, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 5, 6, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 6, 6, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, 6, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 6, 9, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, 9, 1, 0));
        vecs.push_back(mk(1, 5, 6, 1, 0, 0, 0, 6, 9, 1, 1));
        vecs.push_back(mk(1, 6, 6, 1, 0, 0, 0, 6, 9, 1, 1));
        vecs.push_back(mk(1, 6, 9, 1, 0, 0, 0, 6, 9, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 5, 6, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5, 6, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 6, 9, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 6, 9, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].pv, vecs[i].r, vecs[i].w, vecs[i].oc, 1'b0, vecs[i].req);
            check($sformatf("vec%0d_ack", i), rd_ack, vecs[i].e_ack);
            check($sformatf("vec%0d_empty", i), rd_empty, vecs[i].e_empty);
            check($sformatf("vec%0d_old", i), rd_old, vecs[i].e_old);
            check($sformatf("vec%0d_new", i), rd_new, vecs[i].e_new);
            check($sformatf("vec%0d_changed", i), rd_changed, vecs[i].e_chg);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
        end

        // Overflow: eleven captures into eight slots.
        for (int i = 0; i < 11; i++) step(1'b1, W'(i), W'(i + 100), 1'b0, 1'b0, 1'b0);
        check("ovf_count", count, 8);
        check("ovf_drop", drop_cnt, 3);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("ovf_first_old", rd_old, 0);
        check("ovf_first_new", rd_new, 100);
        idle();
        step(1'b1, W'(11), W'(111), 1'b0, 1'b0, 1'b0);
        check("refill_count", count, 8);

        // Full log: capture and accepted read in the same cycle.
        step(1'b1, W'(12), W'(112), 1'b0, 1'b0, 1'b1);
        check("fullpop_count", count, 8);
        check("fullpop_drop", drop_cnt, 3);
        check("fullpop_old", rd_old, 1);
        idle();
        last_new = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            last_new = rd_new;
            idle();
        end
        check("fullpop_8th_new", last_new, 112);
        check("drained_count", count, 0);

        // Clear during a pending response.
        for (int i = 0; i < 4; i++) step(1'b1, W'(20 + i), W'(30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ack_old", rd_old, 20);
        step(1'b1, W'(40), W'(41), 1'b0, 1'b1, 1'b0);
        check("clr_count", count, 0);
        check("clr_drop", drop_cnt, 0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_then_empty", rd_empty, 1);
        idle();

        // Asynchronous reset in the middle of a read burst.
        for (int i = 0; i < 3; i++) step(1'b1, W'(50 + i), W'(60 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n  = 1'b0;
        rd_req = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("postreset_empty", rd_empty, 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
